// File: rtl/sdram_stream_reader.sv
// Prefetching SDRAM-to-audio read streamer: one outstanding read at a time,
// words buffered in a small FIFO and presented on a valid/ready stream.
module sdram_stream_reader #(
  parameter int DEPTH = 8,
  parameter int AW    = 23
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   start,
  input  logic [AW-1:0]          start_addr,
  input  logic [AW-1:0]          end_addr,
  input  logic                   pause,
  input  logic                   stop,
  output logic                   done,
  output logic                   sdram_read,
  output logic [AW-1:0]          sdram_addr,
  input  logic [31:0]            sdram_readdata,
  input  logic                   sdram_finished,
  output logic                   audio_valid,
  output logic [31:0]            audio_data,
  input  logic                   audio_ready,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, ABORT = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] end_addr_q, end_addr_d;
  logic          rd_q, rd_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] next_addr;
  logic          fifo_empty;
  logic          stop_go, flush, push, pop, can_issue;

  assign next_addr  = cur_addr_q + 1'b1;
  assign fifo_empty = (count_q == '0);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      rd_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      rd_q       <= rd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= sdram_readdata;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    rd_d       = rd_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    stop_go   = stop && (state_q != IDLE);
    flush     = stop_go || (state_q == ABORT);
    push      = rd_q && sdram_finished && (state_q == RUN) && !flush;
    pop       = audio_valid && audio_ready;
    can_issue = (state_q == RUN) && !stop && !pause && !rd_q &&
                (cur_addr_q != end_addr_q) && (count_q < DEPTH_C);

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          cur_addr_d = start_addr;
          end_addr_d = end_addr;
          if (start_addr == end_addr) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
            rd_d    = !pause;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = ABORT;
        end else if (push && (next_addr == end_addr_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end else if (stop) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!rd_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      cur_addr_d = next_addr;
    end

    // A completed read always drops the request for a cycle, even while aborting.
    if (rd_q && sdram_finished) begin
      rd_d = 1'b0;
    end else if (can_issue) begin
      rd_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Outputs
  always_comb begin
    sdram_read  = rd_q;
    sdram_addr  = cur_addr_q;
    fifo_level  = count_q;
    audio_valid = !fifo_empty && !pause && (state_q != ABORT);
    audio_data  = fifo_empty ? 32'd0 : mem[rd_ptr_q];
    done        = ((state_q == DRAIN) && fifo_empty) || ((state_q == ABORT) && !rd_q);
  end

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Scoreboard bench: stimulus queues expected SDRAM addresses and audio words,
// an SDRAM model and an output monitor pop and compare them independently.
module tb_sdram_stream_reader;

  localparam int DEPTH = 8;
  localparam int AW    = 23;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          stop  = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] sa    = '0;
  logic [AW-1:0] ea    = '0;
  logic [31:0]   rdata = '0;
  logic          fin   = 1'b0;

  logic          done;
  logic          sdram_read;
  logic [AW-1:0] sdram_addr;
  logic          audio_valid;
  logic [31:0]   audio_data;
  logic [$clog2(DEPTH):0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;
  int n_pops   = 0;
  int done_cnt = 0;
  int sd_lat   = 3;
  int sd_phase = 0;
  int sd_cnt   = 0;
  logic [AW-1:0] sd_req = '0;
  int r0, p0, d0;
  bit seen;

  logic [31:0]   exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];

  sdram_stream_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .start          (start),
    .start_addr     (sa),
    .end_addr       (ea),
    .pause          (pause),
    .stop           (stop),
    .done           (done),
    .sdram_read     (sdram_read),
    .sdram_addr     (sdram_addr),
    .sdram_readdata (rdata),
    .sdram_finished (fin),
    .audio_valid    (audio_valid),
    .audio_data     (audio_data),
    .audio_ready    (ready),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // SDRAM model: answers sdram_lat cycles after a request with data = address.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sd_phase = 0;
        fin      = 1'b0;
      end else begin
        case (sd_phase)
          0: begin
            if (sdram_read) begin
              sd_req = sdram_addr;
              n_reads++;
              chk("read_expected", exp_addr_q.size() != 0, 1);
              if (exp_addr_q.size() != 0) chk("read_addr", sdram_addr, exp_addr_q.pop_front());
              $display("read  addr=0x%06h", sdram_addr);
              sd_cnt   = sd_lat - 1;
              sd_phase = 1;
            end
          end
          1: begin
            chk("read_held", {sdram_read, sdram_addr}, {1'b1, sd_req});
            if (sd_cnt <= 1) begin
              fin      = 1'b1;
              rdata    = 32'(sd_req);
              sd_phase = 2;
            end else begin
              sd_cnt--;
            end
          end
          default: begin
            fin = 1'b0;
            chk("read_gap", sdram_read, 0);
            sd_phase = 0;
          end
        endcase
      end
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pause) chk("valid_gated_by_pause", audio_valid, 0);
        if (audio_valid && ready) begin
          n_pops++;
          $display("pop   data=0x%08h", audio_data);
          chk("pop_expected", exp_data_q.size() != 0, 1);
          if (exp_data_q.size() != 0) chk("audio_data", audio_data, exp_data_q.pop_front());
        end
        if (done) begin
          done_cnt++;
          $display("done  pulse #%0d", done_cnt);
          chk("done_after_last_word", exp_data_q.size(), 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    start = 1'b1;
    sa    = s;
    ea    = e;
    tick(1);
    start = 1'b0;
  endtask

  task automatic expect_range(input logic [AW-1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = s + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(32'(a));
    end
  endtask

  task automatic wait_done(input string nm, input int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick(1);
      if (done) got = 1'b1;
    end
    chk(nm, got, 1);
  endtask

  task automatic mark();
    r0 = n_reads;
    p0 = n_pops;
    d0 = done_cnt;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(3);
    chk("rst_done", done, 0);
    chk("rst_sdram_read", sdram_read, 0);
    chk("rst_sdram_addr", sdram_addr, 0);
    chk("rst_audio_valid", audio_valid, 0);
    chk("rst_audio_data", audio_data, 0);
    chk("rst_fifo_level", fifo_level, 0);
    rst = 1'b0;
    tick(2);

    // Basic stream 0x100..0x103
    sd_lat = 3;
    ready  = 1'b1;
    mark();
    expect_range(AW'('h100), 4);
    run_start(AW'('h100), AW'('h104));
    chk("basic_first_read", {sdram_read, sdram_addr}, {1'b1, AW'('h100)});
    wait_done("basic_done", 200);
    tick(4);
    chk("basic_reads", n_reads - r0, 4);
    chk("basic_pops", n_pops - p0, 4);
    chk("basic_done_once", done_cnt - d0, 1);
    chk("basic_level", fifo_level, 0);

    // Backpressure: 20 words, consumer stalled
    ready = 1'b0;
    mark();
    expect_range(AW'('h400), 20);
    run_start(AW'('h400), AW'('h414));
    tick(80);
    chk("full_level", fifo_level, 8);
    chk("full_reads", n_reads - r0, 8);
    chk("full_no_read", sdram_read, 0);
    chk("full_valid", audio_valid, 1);
    chk("full_head_stable", audio_data, 32'h400);
    ready = 1'b1;
    wait_done("full_done", 400);
    tick(4);
    chk("full_pops", n_pops - p0, 20);
    chk("full_reads_total", n_reads - r0, 20);
    chk("full_done_once", done_cnt - d0, 1);

    // Pause while the 0x205 read is in flight
    mark();
    expect_range(AW'('h200), 10);
    run_start(AW'('h200), AW'('h20A));
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (sdram_read && sdram_addr == AW'('h205)) seen = 1'b1;
    end
    chk("pause_saw_205", seen, 1);
    tick(1);
    pause = 1'b1;
    tick(20);
    chk("pause_level", fifo_level, 1);
    chk("pause_reads", n_reads - r0, 6);
    chk("pause_pops", n_pops - p0, 5);
    chk("pause_no_read", sdram_read, 0);
    chk("pause_no_valid", audio_valid, 0);
    pause = 1'b0;
    wait_done("pause_done", 300);
    tick(4);
    chk("pause_pops_total", n_pops - p0, 10);
    chk("pause_done_once", done_cnt - d0, 1);

    // Stop with a read outstanding
    sd_lat = 5;
    mark();
    exp_addr_q.push_back(AW'('h310));
    run_start(AW'('h310), AW'('h318));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sdram_read) seen = 1'b1;
    end
    chk("stop_saw_read", seen, 1);
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_done("stop_done", 50);
    tick(4);
    chk("stop_level", fifo_level, 0);
    chk("stop_reads", n_reads - r0, 1);
    chk("stop_pops", n_pops - p0, 0);
    chk("stop_done_once", done_cnt - d0, 1);
    chk("stop_idle_no_read", sdram_read, 0);
    sd_lat = 3;

    // Empty range
    mark();
    run_start(AW'('h50), AW'('h50));
    chk("empty_done_next_cycle", done, 1);
    chk("empty_no_read", sdram_read, 0);
    tick(4);
    chk("empty_reads", n_reads - r0, 0);
    chk("empty_done_once", done_cnt - d0, 1);

    // Address wrap
    mark();
    expect_range(AW'('h7FFFFE), 3);
    run_start(AW'('h7FFFFE), AW'('h000001));
    wait_done("wrap_done", 200);
    tick(4);
    chk("wrap_reads", n_reads - r0, 3);
    chk("wrap_pops", n_pops - p0, 3);
    chk("wrap_done_once", done_cnt - d0, 1);
    chk("wrap_addr_queue", exp_addr_q.size(), 0);

    // Reset mid-run with level 5 and a read pending
    ready = 1'b0;
    mark();
    expect_range(AW'('h600), 16);
    run_start(AW'('h600), AW'('h610));
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (sdram_read && fifo_level == 5) seen = 1'b1;
    end
    chk("reset_saw_level5", seen, 1);
    chk("reset_reads_before", n_reads - r0, 6);
    tick(1);
    rst = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    tick(1);
    chk("rrst_done", done, 0);
    chk("rrst_sdram_read", sdram_read, 0);
    chk("rrst_sdram_addr", sdram_addr, 0);
    chk("rrst_audio_valid", audio_valid, 0);
    chk("rrst_audio_data", audio_data, 0);
    chk("rrst_fifo_level", fifo_level, 0);
    rst   = 1'b0;
    ready = 1'b1;
    tick(2);
    mark();
    expect_range(AW'('h700), 3);
    run_start(AW'('h700), AW'('h703));
    wait_done("after_reset_done", 200);
    tick(4);
    chk("after_reset_reads", n_reads - r0, 3);
    chk("after_reset_pops", n_pops - p0, 3);
    chk("after_reset_done_once", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_stream_reader.md
Name: sdram_stream_reader

Overview:
- Prefetching read streamer between the SDRAM bus port and the audio bus playback input.
- Fetches consecutive 32-bit sample words (L in [31:16], R in [15:0]) from SDRAM addresses `start_addr` .. `end_addr-1`.
- Buffers the words in a small FIFO and presents them on a valid/ready stream to the audio bus.
- Start/pause/stop/done control matches the other cores, so the controller can drive it directly.

Parameters:
- DEPTH, 8, FIFO depth in 32-bit words; power of two, 2..64.
- AW, 23, SDRAM word-address width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches start_addr/end_addr; honoured only in IDLE
- start_addr  in  AW  first word address
- end_addr  in  AW  exclusive end address
- pause  in  1  level; while high, no new reads and no output
- stop  in  1  one-cycle pulse; abort stream
- done  out  1  one-cycle pulse at end of stream or after stop completes
- sdram_read  out  1  read request
- sdram_addr  out  AW  read address
- sdram_readdata  in  32  read data, valid when sdram_finished=1
- sdram_finished  in  1  one-cycle completion pulse
- audio_valid  out  1  output word valid
- audio_data  out  32  output word
- audio_ready  in  1  consumer accepts the word
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy (debug)

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; no read outstanding. Reset mid-transaction drops the request immediately.
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_rst).
- States: IDLE, RUN, DRAIN, ABORT.
- IDLE -> RUN on start: latch cur_addr=start_addr and end_addr.
- If start_addr==end_addr at start: go to DRAIN directly; no reads; done is asserted the next cycle.
- SDRAM handshake:
  - sdram_read stays high with sdram_addr held stable until the cycle sdram_finished=1.
  - That cycle, sdram_readdata is written into the FIFO and cur_addr is incremented (mod 2^AW, wraps).
  - sdram_read drops for at least one cycle before the next request.
  - At most one read outstanding.
- Read issue (RUN only): a read is issued when `pause=0`, `cur_addr!=end_addr`, and `fifo_level + outstanding < DEPTH`.
  - First read is asserted the cycle after the start pulse.
- RUN -> DRAIN when the final word is written (cur_addr becomes end_addr).
- DRAIN: no reads; when the FIFO is empty, pulse done for 1 cycle and go to IDLE.
- Output:
  - `audio_valid = !empty && !pause && state!=ABORT`.
  - audio_data = FIFO head, registered storage; a word written in cycle k is visible at k+1 at the earliest.
  - A word is popped on `audio_valid && audio_ready`.
  - audio_data stays stable while `valid && !ready`.
  - Simultaneous push and pop in the same cycle is legal at any level, including full and empty (level unchanged).
- Pause:
  - An in-flight read still completes and is stored.
  - The FIFO holds its contents and resumes on pause=0 with no word lost or duplicated.
  - Pause does not suspend the RUN->DRAIN->done sequence except through the output gating.
- Stop (any non-IDLE state) -> ABORT:
  - If a read is outstanding, keep sdram_read/addr until sdram_finished, then discard the data.
  - Then flush the FIFO, pulse done, go to IDLE.
  - Stop in IDLE is ignored.
  - stop and pause in the same cycle: stop wins.
  - stop and start in the same IDLE cycle: start is ignored.
- start in a non-IDLE state is ignored.
- done never asserts twice for one stream.

Test Plan:
- Basic stream: start_addr=0x100, end_addr=0x104; SDRAM model finishes 3 cycles after each request with data=addr; audio_ready=1 -> exactly 4 reads at 0x100..0x103; audio_data sequence 0x100..0x103; one done pulse after the last pop.
- Backpressure/full: DEPTH=8, 20-word range, audio_ready=0 -> reads stop with fifo_level=8 and no 9th request; set ready=1 -> all 20 words in order, no gaps or duplicates.
- Pause mid-stream: assert pause while a read is in flight at 0x205 -> the 0x205 word is stored; audio_valid=0 and sdram_read stays 0 after that; release pause -> output continues from the next unread word.
- Stop with read outstanding: stop one cycle after request 0x310, finished delayed 5 cycles -> sdram_read held until finished; data not output; FIFO level 0; single done pulse; state IDLE.
- Edge ranges: start_addr=end_addr=0x50 -> no sdram_read, done one cycle later. start_addr=0x7FFFFE, end_addr=0x000001 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000, then done.
- Reset mid-run: assert i_rst while fifo_level=5 and a read is pending -> next cycle all outputs are 0 and fifo_level=0; a subsequent start works normally.
